// File: rtl/spi_seq_pkg.sv
// Shared constants and types for the SPI word sequencer.
package spi_seq_pkg;

  // SPI core register map
  localparam logic [2:0] ADDR_RXDATA   = 3'd0;
  localparam logic [2:0] ADDR_TXDATA   = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_CONTROL  = 3'd3;
  localparam logic [2:0] ADDR_SLAVESEL = 3'd5;
  localparam logic [2:0] ADDR_EOPVAL   = 3'd6;

  // Register-port strobe length in clk cycles
  localparam int unsigned ACCESS_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_WAIT_TX,
    ST_WR_TX,
    ST_WAIT_RX,
    ST_RD_RX,
    ST_GAP,
    ST_OUT
  } seq_state_e;

  typedef enum logic {
    ACC_IDLE,
    ACC_ACTIVE
  } acc_phase_e;

endpackage

// File: rtl/spi_seq_reg_access.sv
// Register-port access engine: one start request produces a strobe of
// ACCESS_CYCLES cycles with chip select, address and data held stable.
// The cycle after an access has select/strobes released, giving the core
// the idle cycle its strobe edge detector needs.
module spi_seq_reg_access
  import spi_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        is_write_i,
  input  logic [2:0]  addr_i,
  input  logic [15:0] wdata_i,
  input  logic [15:0] data_to_cpu_i,
  output logic        done_o,
  output logic [15:0] rdata_o,
  output logic        spi_select_o,
  output logic        write_n_o,
  output logic        read_n_o,
  output logic [2:0]  mem_addr_o,
  output logic [15:0] data_from_cpu_o
);

  acc_phase_e  phase_q, phase_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic        wr_n_q, wr_n_d;
  logic        rd_n_q, rd_n_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        last;

  assign last = (phase_q == ACC_ACTIVE) && (cnt_q == 2'(ACCESS_CYCLES - 1));

  // Next-state for the access phase and the registered register-port drive
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wr_n_d  = wr_n_q;
    rd_n_d  = rd_n_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (phase_q)
      ACC_IDLE: begin
        if (start_i) begin
          phase_d = ACC_ACTIVE;
          cnt_d   = '0;
          sel_d   = 1'b1;
          wr_n_d  = ~is_write_i;
          rd_n_d  = is_write_i;
          addr_d  = addr_i;
          wdata_d = is_write_i ? wdata_i : '0;
        end
      end
      ACC_ACTIVE: begin
        if (last) begin
          phase_d = ACC_IDLE;
          sel_d   = 1'b0;
          wr_n_d  = 1'b1;
          rd_n_d  = 1'b1;
          addr_d  = '0;
          wdata_d = '0;
          if (!rd_n_q) rdata_d = data_to_cpu_i;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: phase_d = ACC_IDLE;
    endcase
  end

  // Access registers; reset releases the strobes immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= ACC_IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign done_o          = last;
  assign rdata_o         = rdata_q;
  assign spi_select_o    = sel_q;
  assign write_n_o       = wr_n_q;
  assign read_n_o        = rd_n_q;
  assign mem_addr_o      = addr_q;
  assign data_from_cpu_o = wdata_q;

endmodule

// File: rtl/spi_word_sequencer.sv
// Streams 16-bit words through the SPI master core register port: one tx
// word in, one full-duplex transfer, one rx word out.
// Optional build macro SPI_SEQ_TIMEOUT_EN adds a WAIT_RX watchdog.
module spi_word_sequencer
  import spi_seq_pkg::*;
#(
  parameter logic [15:0] SLAVE_MASK     = 16'h0001,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        spi_select,
  output logic [2:0]  mem_addr,
  output logic [15:0] data_from_cpu,
  output logic        write_n,
  output logic        read_n,
  input  logic [15:0] data_to_cpu,
  input  logic        dataavailable,
  input  logic        readyfordata,
  output logic        busy,
  output logic [15:0] word_count,
  output logic        timeout_err
);

  seq_state_e  state_q, state_d;
  seq_state_e  gap_next_q, gap_next_d;
  logic [15:0] tx_word_q, tx_word_d;
  logic [15:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_ready_q, tx_ready_d;
  logic        busy_q, busy_d;
  logic [15:0] word_count_q, word_count_d;

  logic        acc_start, acc_write, acc_done;
  logic [2:0]  acc_addr;
  logic [15:0] acc_wdata, acc_rdata;
  logic        tmo_hit;

  spi_seq_reg_access u_acc (
    .clk_i           (clk),
    .rst_i           (reset),
    .start_i         (acc_start),
    .is_write_i      (acc_write),
    .addr_i          (acc_addr),
    .wdata_i         (acc_wdata),
    .data_to_cpu_i   (data_to_cpu),
    .done_o          (acc_done),
    .rdata_o         (acc_rdata),
    .spi_select_o    (spi_select),
    .write_n_o       (write_n),
    .read_n_o        (read_n),
    .mem_addr_o      (mem_addr),
    .data_from_cpu_o (data_from_cpu)
  );

  // Sequencer next-state; the engine ignores start while an access is active,
  // so the access states simply hold start high until done
  always_comb begin
    state_d      = state_q;
    gap_next_d   = gap_next_q;
    tx_word_d    = tx_word_q;
    rx_data_d    = rx_data_q;
    word_count_d = word_count_q;
    acc_start    = 1'b0;
    acc_write    = 1'b1;
    acc_addr     = ADDR_SLAVESEL;
    acc_wdata    = SLAVE_MASK;
    unique case (state_q)
      ST_INIT: begin
        acc_start = 1'b1;
        if (acc_done) begin
          state_d    = ST_GAP;
          gap_next_d = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (tx_valid && tx_ready_q) begin
          tx_word_d = tx_data;
          state_d   = ST_WR_TX;
        end
      end
      ST_WR_TX: begin
        acc_start = 1'b1;
        acc_addr  = ADDR_TXDATA;
        acc_wdata = tx_word_q;
        if (acc_done) begin
          state_d    = ST_GAP;
          gap_next_d = ST_WAIT_RX;
        end
      end
      ST_WAIT_RX: begin
        if (dataavailable)  state_d = ST_RD_RX;
        else if (tmo_hit)   state_d = ST_WAIT_TX;
      end
      ST_RD_RX: begin
        acc_start = 1'b1;
        acc_write = 1'b0;
        acc_addr  = ADDR_RXDATA;
        acc_wdata = '0;
        if (acc_done) begin
          state_d    = ST_GAP;
          gap_next_d = ST_OUT;
        end
      end
      ST_GAP: begin
        state_d = gap_next_q;
        if (gap_next_q == ST_OUT) rx_data_d = acc_rdata;
      end
      ST_OUT: begin
        if (rx_ready) begin
          state_d      = ST_WAIT_TX;
          word_count_d = word_count_q + 16'd1;
        end
      end
      default: state_d = ST_INIT;
    endcase
    tx_ready_d = (state_d == ST_WAIT_TX) && readyfordata;
    rx_valid_d = (state_d == ST_OUT);
    busy_d     = (state_d != ST_WAIT_TX);
  end

  // Sequencer state and stream-side registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      gap_next_q   <= ST_WAIT_TX;
      tx_word_q    <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      tx_ready_q   <= 1'b0;
      busy_q       <= 1'b1;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      gap_next_q   <= gap_next_d;
      tx_word_q    <= tx_word_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      tx_ready_q   <= tx_ready_d;
      busy_q       <= busy_d;
      word_count_q <= word_count_d;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q, tmo_err_d;

  // Watchdog counts cycles spent in WAIT_RX; restarts on every entry
  always_comb begin
    tmo_hit   = (state_q == ST_WAIT_RX) && !dataavailable &&
                (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    tmo_cnt_d = (state_q == ST_WAIT_RX) ? tmo_cnt_q + 1'b1 : '0;
    tmo_err_d = tmo_err_q | tmo_hit;
  end

  // Watchdog counter and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign tx_ready   = tx_ready_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign busy       = busy_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_spi_word_sequencer.sv
// Bench for spi_word_sequencer with a behavioural SPI core (MISO looped to MOSI).
module tb_spi_word_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu;
  logic        write_n;
  logic        read_n;
  logic [15:0] data_to_cpu;
  logic        dataavailable;
  logic        readyfordata;
  logic        busy;
  logic [15:0] word_count;
  logic        timeout_err;

  always #5 clk = ~clk;

  spi_word_sequencer #(
    .SLAVE_MASK     (16'h0001),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .spi_select    (spi_select),
    .mem_addr      (mem_addr),
    .data_from_cpu (data_from_cpu),
    .write_n       (write_n),
    .read_n        (read_n),
    .data_to_cpu   (data_to_cpu),
    .dataavailable (dataavailable),
    .readyfordata  (readyfordata),
    .busy          (busy),
    .word_count    (word_count),
    .timeout_err   (timeout_err)
  );

  // Behavioural SPI core: strobe edge detect, 34-cycle transfer, loopback
  logic        m_trdy, m_rrdy, m_toe, m_roe, m_wprev, m_rprev;
  logic [15:0] m_rxd, m_shreg, m_slvsel;
  logic [5:0]  m_xfer;
  logic [1:0]  m_trdy_cnt;
  logic        force_no_rrdy = 1'b0;

  assign dataavailable = m_rrdy && !force_no_rrdy;
  assign readyfordata  = m_trdy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_trdy <= 1'b1; m_rrdy <= 1'b0; m_toe <= 1'b0; m_roe <= 1'b0;
      m_wprev <= 1'b1; m_rprev <= 1'b1; m_rxd <= '0; m_shreg <= '0;
      m_slvsel <= '0; m_xfer <= '0; m_trdy_cnt <= '0; data_to_cpu <= '0;
    end else begin
      m_wprev <= write_n;
      m_rprev <= read_n;
      data_to_cpu <= (mem_addr == 3'd0) ? m_rxd : 16'h0000;
      if (m_trdy_cnt != 0) begin
        m_trdy_cnt <= m_trdy_cnt - 2'd1;
        if (m_trdy_cnt == 2'd1) m_trdy <= 1'b1;
      end
      if (m_xfer != 0) begin
        m_xfer <= m_xfer - 6'd1;
        if (m_xfer == 6'd1) begin
          if (m_rrdy) m_roe <= 1'b1;
          m_rxd  <= m_shreg;
          m_rrdy <= 1'b1;
        end
      end
      if (spi_select && !write_n && m_wprev) begin
        if (mem_addr == 3'd1) begin
          if (!m_trdy) m_toe <= 1'b1;
          m_shreg    <= data_from_cpu;
          m_trdy     <= 1'b0;
          m_trdy_cnt <= 2'd2;
          m_xfer     <= 6'd34;
        end else if (mem_addr == 3'd5) begin
          m_slvsel <= data_from_cpu;
        end
      end
      if (spi_select && !read_n && m_rprev && mem_addr == 3'd0) m_rrdy <= 1'b0;
    end
  end

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe the post-reset slave-select write until tx_ready rises
  task automatic check_init(input string tag);
    int low = 0, acc = 0, rd = 0, n = 0;
    logic prev = 1'b1, sel_ok = 1'b1;
    logic [2:0] a = '0;
    logic [15:0] d = '0;
    while (!tx_ready && n < 30) begin
      @(negedge clk);
      n++;
      if (!write_n) begin
        low++;
        if (prev) acc++;
        a = mem_addr;
        d = data_from_cpu;
        if (!spi_select) sel_ok = 1'b0;
      end
      if (!read_n) rd++;
      prev = write_n;
    end
    check({tag, "_ready"}, tx_ready, 1);
    check({tag, "_accesses"}, acc, 1);
    check({tag, "_strobe_len"}, low, 2);
    check({tag, "_addr"}, a, 5);
    check({tag, "_data"}, d, 16'h0001);
    check({tag, "_no_read"}, rd, 0);
    check({tag, "_sel"}, sel_ok, 1);
  endtask

  task automatic send(input logic [15:0] w);
    int n = 0;
    while (!tx_ready && n < 200) begin @(negedge clk); n++; end
    check("tx_ready_wait", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = w;
    exp_q.push_back(w);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = '0;
    check("tx_ready_single", tx_ready, 0);
  endtask

  task automatic wait_rx();
    int n = 0;
    while (!rx_valid && n < 300) begin @(negedge clk); n++; end
    check("rx_valid_wait", rx_valid, 1);
  endtask

  task automatic recv(input string tag);
    logic [15:0] e;
    wait_rx();
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
    check(tag, rx_data, e);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check({tag, "_rxv_drop"}, rx_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int viol_v, viol_d, viol_t, viol_s, n;
    logic [15:0] held;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_sel", spi_select, 0);
    check("rst_write_n", write_n, 1);
    check("rst_read_n", read_n, 1);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", data_from_cpu, 0);
    check("rst_busy", busy, 1);
    check("rst_count", word_count, 0);
    check("rst_tmo", timeout_err, 0);
    reset = 1'b0;

    // 1: init write of slave mask
    check_init("init");
    check("init_core_slvsel", m_slvsel, 16'h0001);
    check("idle_busy", busy, 0);

    // 2: single transfer with loopback
    send(16'hA5C3);
    recv("rx_a5c3");
    check("count_1", word_count, 1);

    // 3: consumer stall keeps output stable and blocks new work
    send(16'h5A5A);
    wait_rx();
    held = rx_data;
    viol_v = 0; viol_d = 0; viol_t = 0; viol_s = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rx_valid !== 1'b1) viol_v++;
      if (rx_data !== held) viol_d++;
      if (tx_ready !== 1'b0) viol_t++;
      if (spi_select !== 1'b0 || write_n !== 1'b1 || read_n !== 1'b1) viol_s++;
    end
    check("stall_rx_valid", viol_v, 0);
    check("stall_rx_data", viol_d, 0);
    check("stall_tx_ready", viol_t, 0);
    check("stall_no_access", viol_s, 0);
    recv("rx_5a5a");
    check("count_2", word_count, 2);

    // 4: sequence of edge-case words
    send(16'h0000); recv("rx_0000");
    send(16'hFFFF); recv("rx_ffff");
    send(16'h1234); recv("rx_1234");
    check("count_5", word_count, 5);
    check("core_toe", m_toe, 0);
    check("core_roe", m_roe, 0);

    // 5: reset during second cycle of the TXDATA write
    send(16'hBEEF);
    n = 0;
    while (!(write_n === 1'b0 && mem_addr === 3'd1) && n < 20) begin @(negedge clk); n++; end
    check("wr_tx_seen", write_n, 0);
    @(posedge clk);
    #1;
    check("wr_tx_cycle2", write_n, 0);
    reset = 1'b1;
    #1;
    check("abort_write_n", write_n, 1);
    check("abort_sel", spi_select, 0);
    check("abort_busy", busy, 1);
    check("abort_count", word_count, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check_init("reinit");

    // 6: no RRDY from the core
    force_no_rrdy = 1'b1;
    send(16'h0F0F);
`ifdef SPI_SEQ_TIMEOUT_EN
    repeat (19) @(negedge clk);
    check("tmo_not_yet", timeout_err, 0);
    @(negedge clk);
    check("tmo_set", timeout_err, 1);
    check("tmo_tx_ready", tx_ready, 1);
    check("tmo_rx_valid", rx_valid, 0);
    check("tmo_count", word_count, 0);
    repeat (5) @(negedge clk);
    check("tmo_sticky", timeout_err, 1);
    check("tmo_idle", busy, 0);
    void'(exp_q.pop_front());
`else
    repeat (60) @(negedge clk);
    check("norx_busy", busy, 1);
    check("norx_tx_ready", tx_ready, 0);
    check("norx_rx_valid", rx_valid, 0);
    check("norx_tmo", timeout_err, 0);
    force_no_rrdy = 1'b0;
    recv("rx_0f0f");
    check("norx_count", word_count, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
